img_pkt_rx: RTL

- Parametrised successor to the photo-frame image receiver. Parses a framed image stream from uart_rx bytes and assembles multi-byte pixels of configurable width.
- Writes pixels to the frame RAM port and verifies a per-packet checksum. Replies ACK or NAK through the UART tx mux; on NAK it rewinds so the host can retransmit the packet.
- Adds an inter-byte timeout and a retry limit.

---
 rtl/img_pkt_rx.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/img_pkt_rx.sv
// Framed image receiver: parses SOF/W/H header and checksummed pixel packets from UART bytes,
// writes assembled pixels to frame RAM and answers each header/packet with ACK or NAK.
module img_pkt_rx #(
    parameter int unsigned PIX_W       = 12,
    parameter int unsigned PKT_PIX     = 16,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned MAX_PIX     = 40000,
    parameter int unsigned TIMEOUT_CYC = 5000000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [7:0]  SOF         = 8'hA5,
    parameter logic [7:0]  ACK         = 8'h06,
    parameter logic [7:0]  NAK         = 8'h15
) (
    input  logic              i_clk_sys,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_done,
    input  logic              i_enable,
    output logic [7:0]        o_reply_data,
    output logic              o_reply_valid,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [PIX_W-1:0]  o_wr_data,
    output logic [7:0]        o_width,
    output logic [7:0]        o_height,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_error
);

    localparam int unsigned BPP   = (PIX_W + 7) / 8;
    localparam int unsigned SR_W  = BPP * 8;
    localparam int unsigned BC_W  = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned RT_W  = $clog2(MAX_RETRY + 1);
    localparam int unsigned TOT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_W, S_HDR_H, S_HDR_CHK, S_PIX, S_CSUM
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        width_q, width_d, height_q, height_d;
    logic [7:0]        save_w_q, save_w_d, save_h_q, save_h_d;
    logic [TOT_W-1:0]  total_q, total_d;
    logic              hdr_ok_q, hdr_ok_d;
    logic [TOT_W-1:0]  addr_q, addr_d, base_q, base_d, pkt_cnt_q, pkt_cnt_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [RT_W-1:0]   retry_q, retry_d;
    logic [7:0]        csum_q, csum_d;
    logic [SR_W-1:0]   pix_sr_q, pix_sr_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        reply_data_q, reply_data_d;
    logic              reply_valid_q, reply_valid_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              error_q, error_d;

    logic [SR_W-1:0]   shifted_c;
    logic [TOT_W-1:0]  total_c, remain_c, pkt_n_c;
    logic              hdr_bad_c, timeout_c;

    // State and datapath registers
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            width_q       <= '0;
            height_q      <= '0;
            save_w_q      <= '0;
            save_h_q      <= '0;
            total_q       <= '0;
            hdr_ok_q      <= 1'b0;
            addr_q        <= '0;
            base_q        <= '0;
            pkt_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            retry_q       <= '0;
            csum_q        <= '0;
            pix_sr_q      <= '0;
            to_cnt_q      <= '0;
            reply_data_q  <= '0;
            reply_valid_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            width_q       <= width_d;
            height_q      <= height_d;
            save_w_q      <= save_w_d;
            save_h_q      <= save_h_d;
            total_q       <= total_d;
            hdr_ok_q      <= hdr_ok_d;
            addr_q        <= addr_d;
            base_q        <= base_d;
            pkt_cnt_q     <= pkt_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            retry_q       <= retry_d;
            csum_q        <= csum_d;
            pix_sr_q      <= pix_sr_d;
            to_cnt_q      <= to_cnt_d;
            reply_data_q  <= reply_data_d;
            reply_valid_q <= reply_valid_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            error_q       <= error_d;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d       = state_q;
        width_d       = width_q;
        height_d      = height_q;
        save_w_d      = save_w_q;
        save_h_d      = save_h_q;
        total_d       = total_q;
        hdr_ok_d      = hdr_ok_q;
        addr_d        = addr_q;
        base_d        = base_q;
        pkt_cnt_d     = pkt_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        retry_d       = retry_q;
        csum_d        = csum_q;
        pix_sr_d      = pix_sr_q;
        to_cnt_d      = '0;
        reply_data_d  = reply_data_q;
        reply_valid_d = 1'b0;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_done_d  = 1'b0;
        error_d       = 1'b0;

        shifted_c = (pix_sr_q << 8) | SR_W'(i_rx_data);
        total_c   = TOT_W'(width_q) * TOT_W'(i_rx_data);
        hdr_bad_c = (total_c == '0) || (32'(total_c) > 32'(MAX_PIX));
        remain_c  = total_q - base_q;
        pkt_n_c   = (remain_c < TOT_W'(PKT_PIX)) ? remain_c : TOT_W'(PKT_PIX);
        timeout_c = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) && !i_rx_done;

        if (state_q != S_IDLE) begin
            to_cnt_d = i_rx_done ? '0 : to_cnt_q + TO_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_enable && i_rx_done && (i_rx_data == SOF)) begin
                    save_w_d = width_q;
                    save_h_d = height_q;
                    state_d  = S_HDR_W;
                end
            end
            S_HDR_W: begin
                if (i_rx_done) begin
                    width_d = i_rx_data;
                    state_d = S_HDR_H;
                end
            end
            S_HDR_H: begin
                // Header verdict is decided on the height byte so the reply lands one cycle later
                if (i_rx_done) begin
                    height_d      = i_rx_data;
                    total_d       = total_c;
                    hdr_ok_d      = !hdr_bad_c;
                    reply_valid_d = 1'b1;
                    reply_data_d  = hdr_bad_c ? NAK : ACK;
                    state_d       = S_HDR_CHK;
                end
            end
            S_HDR_CHK: begin
                if (hdr_ok_q) begin
                    addr_d     = '0;
                    base_d     = '0;
                    retry_d    = '0;
                    csum_d     = '0;
                    pkt_cnt_d  = '0;
                    byte_cnt_d = '0;
                    state_d    = S_PIX;
                end else begin
                    width_d  = save_w_q;
                    height_d = save_h_q;
                    state_d  = S_IDLE;
                end
            end
            S_PIX: begin
                if (i_rx_done) begin
                    csum_d   = csum_q + i_rx_data;
                    pix_sr_d = shifted_c;
                    if (byte_cnt_q == BC_W'(BPP - 1)) begin
                        byte_cnt_d = '0;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = ADDR_W'(addr_q);
                        wr_data_d  = PIX_W'(shifted_c);
                        addr_d     = addr_q + TOT_W'(1);
                        pkt_cnt_d  = pkt_cnt_q + TOT_W'(1);
                        if ((pkt_cnt_q + TOT_W'(1)) == pkt_n_c) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                    end
                end
            end
            S_CSUM: begin
                if (i_rx_done) begin
                    csum_d     = '0;
                    pkt_cnt_d  = '0;
                    byte_cnt_d = '0;
                    if (i_rx_data == csum_q) begin
                        reply_valid_d = 1'b1;
                        reply_data_d  = ACK;
                        base_d        = addr_q;
                        retry_d       = '0;
                        if (addr_q == total_q) begin
                            frame_done_d = 1'b1;
                            state_d      = S_IDLE;
                        end else begin
                            state_d = S_PIX;
                        end
                    end else begin
                        // Rewind to the packet start; the final allowed failure aborts silently
                        addr_d = base_q;
                        if ((retry_q + RT_W'(1)) == RT_W'(MAX_RETRY)) begin
                            retry_d = '0;
                            error_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            retry_d       = retry_q + RT_W'(1);
                            reply_valid_d = 1'b1;
                            reply_data_d  = NAK;
                            state_d       = S_PIX;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout or disable mid-frame aborts without a reply
        if ((state_q != S_IDLE) && (!i_enable || timeout_c)) begin
            state_d       = S_IDLE;
            error_d       = 1'b1;
            reply_valid_d = 1'b0;
            frame_done_d  = 1'b0;
            wr_en_d       = 1'b0;
            to_cnt_d      = '0;
            csum_d        = '0;
            pkt_cnt_d     = '0;
            byte_cnt_d    = '0;
            retry_d       = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign o_reply_data  = reply_data_q;
    assign o_reply_valid = reply_valid_q;
    assign o_wr_en       = wr_en_q;
    assign o_wr_addr     = wr_addr_q;
    assign o_wr_data     = wr_data_q;
    assign o_width       = width_q;
    assign o_height      = height_q;
    assign o_busy        = busy_q;
    assign o_frame_done  = frame_done_q;
    assign o_error       = error_q;

endmodule
